// File: rtl/grid_map.sv
`default_nettype none
// ============================================================================
// Module   : grid_map
// Purpose  : 64x32 map of 3-bit cells with zero-latency lookup, bordered clear
//            sweep, streamed full-map load and single-cell point writes.
// Revision : 1.0  initial release
// ============================================================================
module grid_map #(
  parameter logic [2:0] BORDER_CELL = 3'd1,
  parameter logic [2:0] BUSY_CELL   = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] grid_x,
  input  logic [4:0] grid_y,
  output logic [2:0] grid_out,
  input  logic       clear_start,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [2:0] load_data,
  output logic       load_ready,
  output logic       load_done,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_data,
  output logic       busy
);

  localparam logic [10:0] C_LAST_ADDR = 11'd2047;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_addr;
  logic [10:0] w_addr_nxt;
  logic        w_we;
  logic [10:0] w_waddr;
  logic [2:0]  w_wdata;
  logic        w_on_border;

  logic [2:0]  r_mem [0:2047];

  // Perimeter test on the sweep address, split as {y[4:0], x[5:0]}.
  assign w_on_border = (r_addr[5:0] == 6'd0) || (r_addr[5:0] == 6'd63) ||
                       (r_addr[10:6] == 5'd0) || (r_addr[10:6] == 5'd31);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_addr  <= 11'd0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_we        = 1'b0;
    w_waddr     = r_addr;
    w_wdata     = 3'd0;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_wdata = w_on_border ? BORDER_CELL : 3'd0;
        if (r_addr == C_LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = 11'd0;
        end else begin
          w_addr_nxt = r_addr + 11'd1;
        end
      end
      ST_IDLE: begin
        busy = 1'b0;
        // Lower-priority requests arriving alongside a higher one are dropped.
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
          w_addr_nxt  = 11'd0;
        end else if (load_start) begin
          w_state_nxt = ST_LOAD;
          w_addr_nxt  = 11'd0;
        end else if (wr_en) begin
          w_we    = 1'b1;
          w_waddr = {wr_y, wr_x};
          w_wdata = wr_data;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_we    = 1'b1;
          w_wdata = load_data;
          if (r_addr == C_LAST_ADDR) begin
            w_state_nxt = ST_DONE;
            w_addr_nxt  = 11'd0;
          end else begin
            w_addr_nxt = r_addr + 11'd1;
          end
        end
      end
      default: begin
        load_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Writes are suppressed during reset so an aborted load leaves no stray cell.
  always_ff @(posedge clock) begin
    if (w_we && !reset) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign grid_out = busy ? BUSY_CELL : r_mem[{grid_y, grid_x}];

endmodule
`default_nettype wire

// File: tb/tb_grid_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_map
// Purpose  : Scoreboard-driven self-checking bench for grid_map.
// Revision : 1.0  initial release
// ============================================================================
module tb_grid_map;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] grid_x = 6'd0;
  logic [4:0] grid_y = 5'd0;
  logic [2:0] grid_out;
  logic       clear_start = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [2:0] load_data = 3'd0;
  logic       load_ready;
  logic       load_done;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = 6'd0;
  logic [4:0] wr_y = 5'd0;
  logic [2:0] wr_data = 3'd0;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_count = 0;
  int done_pulses = 0;
  int sb_q[$];

  grid_map dut (
    .clock       (clock),
    .reset       (reset),
    .grid_x      (grid_x),
    .grid_y      (grid_y),
    .grid_out    (grid_out),
    .clear_start (clear_start),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (load_valid && load_ready) hs_count++;
    if (load_done) done_pulses++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [2:0] pat(input int idx);
    logic [10:0] a;
    a = 11'(idx);
    return 3'(a[5:0] + 6'(a[10:6]));
  endfunction

  // Expected cell pushed with the coordinates, popped when grid_out is sampled.
  task automatic probe(input string tag, input int x, input int y, input int exp);
    int e;
    grid_x = 6'(x);
    grid_y = 5'(y);
    sb_q.push_back(exp);
    @(negedge clock);
    e = sb_q.pop_front();
    check(tag, int'(grid_out), e);
  endtask

  task automatic wait_sweep(input string tag);
    int  cyc = 0;
    bit  bad_busy_cell = 0;
    bit  saw_ready = 0;
    grid_x = 6'd10;
    grid_y = 5'd5;
    do begin
      @(posedge clock); #1;
      cyc++;
      if (busy && grid_out !== 3'd7) bad_busy_cell = 1;
      if (load_ready) saw_ready = 1;
    end while (busy && cyc < 3000);
    check({tag, "_cycles"}, cyc, 2048);
    check({tag, "_busycell"}, int'(bad_busy_cell), 0);
    check({tag, "_noready"}, int'(saw_ready), 0);
  endtask

  // Streams the pattern until stop_at cells are accepted; toggling valid if asked.
  task automatic stream(input int stop_at, input bit toggle, output int accepted);
    int idx = 0;
    int cyc = 0;
    bit v = 1;
    while (idx < stop_at && cyc < 10000) begin
      load_valid = v;
      load_data  = pat(idx);
      wr_en      = (cyc == 100);
      wr_x       = 6'd13;
      wr_y       = 5'd7;
      wr_data    = 3'd3;
      #1;
      if (load_valid && load_ready) idx++;
      @(posedge clock); #1;
      if (toggle) v = !v;
      cyc++;
    end
    wr_en = 1'b0;
    accepted = idx;
  endtask

  initial begin
    int acc;
    int hs0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 1);
    check("rst_grid", int'(grid_out), 7);
    check("rst_ready", int'(load_ready), 0);
    check("rst_done", int'(load_done), 0);
    reset = 1'b0;
    wait_sweep("sweep0");
    probe("arena_0_0", 0, 0, 1);
    probe("arena_63_31", 63, 31, 1);
    probe("arena_10_5", 10, 5, 0);
    probe("arena_62_30", 62, 30, 0);

    // Point write; old value visible until the write edge.
    @(posedge clock); #1;
    wr_en = 1'b1; wr_x = 6'd12; wr_y = 5'd7; wr_data = 3'd5;
    grid_x = 6'd12; grid_y = 5'd7;
    #1 check("rdw_old", int'(grid_out), 0);
    @(posedge clock); #1;
    wr_en = 1'b0;
    probe("wr_12_7", 12, 7, 5);
    probe("wr_13_7", 13, 7, 0);

    // Stream load with valid toggling; a point write during it must be ignored.
    @(posedge clock); #1;
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
    check("load_ready_on", int'(load_ready), 1);
    hs0 = hs_count;
    stream(2048, 1'b1, acc);
    check("load_accepted", acc, 2048);
    load_valid = 1'b0;
    #1;
    check("load_ready_off", int'(load_ready), 0);
    check("load_done_hi", int'(load_done), 1);
    check("load_busy_done", int'(busy), 1);
    @(posedge clock); #1;
    check("load_done_lo", int'(load_done), 0);
    check("load_busy_lo", int'(busy), 0);
    check("load_handshakes", hs_count - hs0, 2048);
    check("load_done_pulses", done_pulses, 1);
    probe("load_5_3", 5, 3, 0);
    probe("load_63_31", 63, 31, 6);
    probe("load_7_0", 7, 0, 7);
    probe("load_13_7", 13, 7, int'(pat(7 * 64 + 13)));

    // All three requests together: clear wins.
    @(posedge clock); #1;
    clear_start = 1'b1; load_start = 1'b1;
    wr_en = 1'b1; wr_x = 6'd12; wr_y = 5'd7; wr_data = 3'd6;
    @(posedge clock); #1;
    clear_start = 1'b0; load_start = 1'b0; wr_en = 1'b0;
    wait_sweep("sweep_cmd");
    probe("cmd_wr_cleared", 12, 7, 0);
    probe("cmd_63_31", 63, 31, 1);

    // Reset in the middle of a load.
    @(posedge clock); #1;
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
    stream(1000, 1'b0, acc);
    check("partial_accepted", acc, 1000);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_busy", int'(busy), 1);
    check("abort_ready", int'(load_ready), 0);
    check("abort_grid", int'(grid_out), 7);
    reset = 1'b0;
    load_valid = 1'b0;
    wait_sweep("sweep_abort");
    check("abort_no_done", done_pulses, 1);
    probe("abort_5_3", 5, 3, 0);
    probe("abort_7_0", 7, 0, 1);
    probe("abort_63_31", 63, 31, 1);
    probe("abort_30_15", 30, 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grid_map.md
# grid_map

Map storage and responder for the ray-casting engine. Holds the 64×32 grid of 3-bit cells and answers raytracer lookups combinationally (grid_x/grid_y → grid_out in the same cycle). It also provides the write side of the map:
- a reset/commanded clear sweep that builds a bordered empty arena;
- a streamed full-map load with valid/ready handshake;
- single-cell point writes.

## Interface
- BORDER_CELL, 3'd1: value written to perimeter cells by a clear sweep.
- BUSY_CELL, 3'd7: value driven on grid_out while busy. Nonzero, so any ray in flight terminates.
- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- grid_x  input  6  read column, 0..63.
- grid_y  input  5  read row, 0..31.
- grid_out  output  3  cell contents at (grid_x, grid_y); 0 = empty.
- clear_start  input  1  one-cycle request to run a clear sweep.
- load_start  input  1  one-cycle request to begin a full-map stream load.
- load_valid  input  1  load_data is valid.
- load_data  input  3  next cell value, row-major (x fastest).
- load_ready  output  1  block accepts load_data this cycle.
- load_done  output  1  one-cycle pulse after the last streamed cell is written.
- wr_en  input  1  point write strobe.
- wr_x  input  6  point write column.
- wr_y  input  5  point write row.
- wr_data  input  3  point write value.
- busy  output  1  high in CLEAR, LOAD, DONE.

## Operation
- Storage is 2048 × 3 bits with asynchronous read. Address = {y, x} (11 bits).
- grid_out = BUSY_CELL when busy, else mem[{grid_y, grid_x}].
- States: CLEAR, IDLE, LOAD, DONE. An 11-bit address counter `addr` is shared by CLEAR and LOAD.
- CLEAR:
  - Each cycle writes mem[addr] = BORDER_CELL if x==0 or x==63 or y==0 or y==31, else 0.
  - Then addr++.
  - After writing addr 2047 → IDLE, addr = 0.
- IDLE: input priority is clear_start > load_start > wr_en. Lower-priority requests in the same cycle are dropped.
  - clear_start → CLEAR, addr = 0.
  - load_start → LOAD, addr = 0.
  - wr_en → mem[{wr_y, wr_x}] = wr_data this edge; stay IDLE.
- LOAD:
  - load_ready = 1.
  - On load_valid && load_ready: mem[addr] = load_data, addr++.
  - Stalls indefinitely while load_valid = 0.
  - After the write to addr 2047 → DONE.
- DONE: load_done = 1 for one cycle → IDLE.
- Ignored while not IDLE: wr_en, clear_start, load_start. No queueing.
- The counter wraps only by state exit; addr never exceeds 2047.

## Timing
- Reset (sync):
  - state = CLEAR, addr = 0.
  - Outputs during and after reset: busy = 1, load_ready = 0, load_done = 0, grid_out = BUSY_CELL.
- Memory contents are not reset directly. The clear sweep starts on the first edge with reset low.
- Reset mid-LOAD or mid-CLEAR aborts the operation and restarts the sweep at addr 0. Partially loaded data is overwritten.
- Clear latency: 2048 cycles after reset deassertion or clear_start acceptance. busy falls on the edge that writes cell 2047.
- Load: minimum 2048 accepting cycles + 1 DONE cycle.
  - load_ready falls on the edge that writes cell 2047.
  - load_done is high the following cycle; busy falls after it.
- Point write is visible on grid_out the cycle after the write edge. Read-during-write returns the old value.
- Read path is purely combinational, zero latency. This is required: the raytracer samples grid_out in the same cycle it presents its coordinates.

## Test plan
- Reset held 3 cycles, then released:
  - busy = 1 and grid_out = 7 for 2048 cycles, then busy = 0.
  - (0,0) → 1, (63,31) → 1, (10,5) → 0, (62,30) → 0.
- IDLE, wr_en with (12,7,3'd5):
  - next cycle (12,7) reads 5, (13,7) reads 0.
  - a second wr_en while busy changes nothing.
- load_start, then stream value (x+y)%8 with load_valid toggling every other cycle:
  - exactly 2048 handshakes; load_done pulses once.
  - (5,3) reads 0, (63,31) reads 6, (7,0) reads 7.
- clear_start, load_start and wr_en in the same IDLE cycle:
  - CLEAR runs; no load_ready; the wr target is cleared.
- Reset asserted at load cell 1000:
  - sweep restarts; after 2048 cycles the map is the bordered empty arena; load_done never pulses.
- Reset deasserted, then raytracer at (10,5) and ray start asserted during sweep:
  - grid_out = 7, so the ray reports done at its start cell.
